// File: rtl/conv2d_frame_ctrl.sv
// Frame sequencer for the conv2d Sobel datapath: gates one frame of pixels in,
// appends zero pad beats to flush the pipeline, and tags each window result.
module conv2d_frame_ctrl #(
   parameter int WIDTH_P      = 8,
   parameter int COLS_P       = 16,
   parameter int ROWS_P       = 16,
   parameter int PIPE_BEATS_P = 1
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      start_i,
   input  logic                      abort_i,
   output logic                      busy_o,
   output logic                      done_o,
   input  logic                      s_valid_i,
   output logic                      s_ready_o,
   input  logic [WIDTH_P-1:0]        s_data_i,
   output logic                      c_valid_o,
   input  logic                      c_ready_i,
   output logic [WIDTH_P-1:0]        c_data_o,
   output logic                      res_valid_o,
   output logic [$clog2(ROWS_P)-1:0] res_row_o,
   output logic [$clog2(COLS_P)-1:0] res_col_o,
   output logic                      res_last_o
);

   localparam int RW = $clog2(ROWS_P);
   localparam int CW = $clog2(COLS_P);
   localparam int PW = $clog2(PIPE_BEATS_P + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [RW-1:0]   row_r;
   logic [CW-1:0]   col_r;
   logic [PW-1:0]   pad_r;
   logic            busy_r;
   logic            done_r;

   logic            beat_s;
   logic            abort_s;
   logic            last_pix_s;
   logic            last_pad_s;

   logic            push_v_s;
   logic [RW-1:0]   push_row_s;
   logic [CW-1:0]   push_col_s;

   logic            tag_v_r   [PIPE_BEATS_P];
   logic [RW-1:0]   tag_row_r [PIPE_BEATS_P];
   logic [CW-1:0]   tag_col_r [PIPE_BEATS_P];

   logic            res_valid_r;
   logic [RW-1:0]   res_row_r;
   logic [CW-1:0]   res_col_r;
   logic            res_last_r;

   // Abort only matters once a frame is under way.
   assign abort_s    = abort_i && (state_r != S_IDLE);
   assign beat_s     = c_valid_o && c_ready_i;
   assign last_pix_s = (row_r == RW'(ROWS_P - 1)) && (col_r == CW'(COLS_P - 1));
   assign last_pad_s = (pad_r == PW'(1));

   // Stream routing: pixels pass through in RUN, zero pads are forced in DRAIN.
   always_comb begin
      c_valid_o = 1'b0;
      c_data_o  = '0;
      s_ready_o = 1'b0;
      case (state_r)
         S_RUN: begin
            c_valid_o = s_valid_i;
            c_data_o  = s_data_i;
            s_ready_o = c_ready_i;
         end
         S_DRAIN: begin
            c_valid_o = 1'b1;
         end
         default: begin
            c_valid_o = 1'b0;
         end
      endcase
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_s = state_r;
      if (abort_s) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_i) begin
                  state_s = S_RUN;
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_RUN: begin
               if (beat_s && last_pix_s) begin
                  state_s = S_DRAIN;
               end else begin
                  state_s = S_RUN;
               end
            end
            S_DRAIN: begin
               if (beat_s && last_pad_s) begin
                  state_s = S_DONE;
               end else begin
                  state_s = S_DRAIN;
               end
            end
            S_DONE: begin
               state_s = S_IDLE;
            end
            default: begin
               state_s = S_IDLE;
            end
         endcase
      end
   end

   // State register with busy/done decoded from the next state so they are flopped.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_r <= S_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == S_RUN) || (state_s == S_DRAIN);
         done_r  <= (state_s == S_DONE);
      end
   end

   // Pixel position and pad counters; they move only on accepted beats.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         row_r <= '0;
         col_r <= '0;
         pad_r <= '0;
      end else if (abort_s) begin
         row_r <= '0;
         col_r <= '0;
         pad_r <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_i) begin
                  row_r <= '0;
                  col_r <= '0;
               end
            end
            S_RUN: begin
               if (beat_s) begin
                  if (last_pix_s) begin
                     row_r <= '0;
                     col_r <= '0;
                     pad_r <= PW'(PIPE_BEATS_P);
                  end else if (col_r == CW'(COLS_P - 1)) begin
                     col_r <= '0;
                     row_r <= row_r + RW'(1);
                  end else begin
                     col_r <= col_r + CW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (beat_s) begin
                  pad_r <= pad_r - PW'(1);
               end
            end
            default: begin
               pad_r <= pad_r;
            end
         endcase
      end
   end

   // The c>=2 term masks windows that straddle a row wrap.
   always_comb begin
      push_v_s   = 1'b0;
      push_row_s = '0;
      push_col_s = '0;
      if (state_r == S_RUN) begin
         push_v_s   = (row_r >= RW'(2)) && (col_r >= CW'(2));
         push_row_s = row_r - RW'(1);
         push_col_s = col_r - CW'(1);
      end else begin
         push_v_s   = 1'b0;
      end
   end

   // Tag shift register mirrors the conv2d pipeline, advancing only on beats.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < PIPE_BEATS_P; i++) begin
            tag_v_r[i]   <= 1'b0;
            tag_row_r[i] <= '0;
            tag_col_r[i] <= '0;
         end
      end else if (abort_s) begin
         for (int i = 0; i < PIPE_BEATS_P; i++) begin
            tag_v_r[i]   <= 1'b0;
            tag_row_r[i] <= '0;
            tag_col_r[i] <= '0;
         end
      end else if (beat_s) begin
         tag_v_r[0]   <= push_v_s;
         tag_row_r[0] <= push_row_s;
         tag_col_r[0] <= push_col_s;
         for (int i = 1; i < PIPE_BEATS_P; i++) begin
            tag_v_r[i]   <= tag_v_r[i-1];
            tag_row_r[i] <= tag_row_r[i-1];
            tag_col_r[i] <= tag_col_r[i-1];
         end
      end
   end

   // Result tag: captures the entry leaving the pipeline on each beat.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         res_valid_r <= 1'b0;
         res_row_r   <= '0;
         res_col_r   <= '0;
         res_last_r  <= 1'b0;
      end else if (abort_s) begin
         res_valid_r <= 1'b0;
         res_row_r   <= '0;
         res_col_r   <= '0;
         res_last_r  <= 1'b0;
      end else if (beat_s) begin
         res_valid_r <= tag_v_r[PIPE_BEATS_P-1];
         res_row_r   <= tag_row_r[PIPE_BEATS_P-1];
         res_col_r   <= tag_col_r[PIPE_BEATS_P-1];
         res_last_r  <= tag_v_r[PIPE_BEATS_P-1]
                        && (tag_row_r[PIPE_BEATS_P-1] == RW'(ROWS_P - 2))
                        && (tag_col_r[PIPE_BEATS_P-1] == CW'(COLS_P - 2));
      end else begin
         res_valid_r <= 1'b0;
         res_last_r  <= 1'b0;
      end
   end

   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign res_valid_o = res_valid_r;
   assign res_row_o   = res_row_r;
   assign res_col_o   = res_col_r;
   assign res_last_o  = res_last_r;

endmodule

// File: tb/tb_conv2d_frame_ctrl.sv
// Bench for conv2d_frame_ctrl: two 4x4 instances (pipeline depth 1 and 2) share
// randomized stimulus and are checked against a beat-indexed reference model.
module tb_conv2d_frame_ctrl;

   localparam int NR = 4;
   localparam int NC = 4;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;
   logic       abort;
   logic       s_valid;
   logic       c_ready;
   logic [7:0] s_data;

   logic       busy    [2];
   logic       done    [2];
   logic       s_ready [2];
   logic       c_valid [2];
   logic [7:0] c_data  [2];
   logic       rv      [2];
   logic [1:0] rr      [2];
   logic [1:0] rc      [2];
   logic       rl      [2];

   int n_cmp = 0;
   int n_bad = 0;

   int m_phase [2];
   int m_pix   [2];
   int m_pads  [2];
   int m_nb    [2];
   int m_frames[2];
   int m_tag   [2][32];
   int e_rv [2];
   int e_rr [2];
   int e_rc [2];
   int e_rl [2];

   int o_pix [2];
   int o_pad [2];
   int o_res [2];
   int o_last[2];
   int o_done[2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      conv2d_frame_ctrl #(
         .WIDTH_P(8), .COLS_P(NC), .ROWS_P(NR), .PIPE_BEATS_P(g + 1)
      ) u_dut (
         .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
         .busy_o(busy[g]), .done_o(done[g]),
         .s_valid_i(s_valid), .s_ready_o(s_ready[g]), .s_data_i(s_data),
         .c_valid_o(c_valid[g]), .c_ready_i(c_ready), .c_data_o(c_data[g]),
         .res_valid_o(rv[g]), .res_row_o(rr[g]), .res_col_o(rc[g]),
         .res_last_o(rl[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int g = 0; g < 2; g++) begin
         m_phase[g] = M_IDLE;
         m_nb[g] = 0;
         e_rv[g] = 0; e_rr[g] = 0; e_rc[g] = 0; e_rl[g] = 0;
      end
   endtask

   task automatic clear_obs();
      for (int g = 0; g < 2; g++) begin
         o_pix[g] = 0; o_pad[g] = 0; o_res[g] = 0; o_last[g] = 0; o_done[g] = 0;
         m_frames[g] = 0;
      end
   endtask

   // Record the tag of this beat; the result leaving the pipe belongs to beat nb-P.
   task automatic push(input int g, input int t);
      int k;
      m_tag[g][m_nb[g]] = t;
      if (m_nb[g] >= g + 1) begin
         k = m_tag[g][m_nb[g] - (g + 1)];
         if (k >= 0 && (k / NC) >= 2 && (k % NC) >= 2) begin
            e_rv[g] = 1;
            e_rr[g] = k / NC - 1;
            e_rc[g] = k % NC - 1;
            e_rl[g] = (e_rr[g] == NR - 2 && e_rc[g] == NC - 2) ? 1 : 0;
         end
      end
      m_nb[g]++;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int g = 0; g < 2; g++) begin
         chk({tag, "_busy"},    busy[g],    0);
         chk({tag, "_done"},    done[g],    0);
         chk({tag, "_cvalid"},  c_valid[g], 0);
         chk({tag, "_sready"},  s_ready[g], 0);
         chk({tag, "_rvalid"},  rv[g],      0);
         chk({tag, "_rlast"},   rl[g],      0);
         chk({tag, "_rrow"},    rr[g],      0);
         chk({tag, "_rcol"},    rc[g],      0);
      end
   endtask

   // One clock: check combinational stream outputs, cross the edge, advance the model.
   task automatic tick();
      int ecv;
      int bt[2];
      #1;
      for (int g = 0; g < 2; g++) begin
         ecv = (m_phase[g] == M_RUN) ? int'(s_valid) : (m_phase[g] == M_DRAIN) ? 1 : 0;
         chk("c_valid", c_valid[g], ecv);
         chk("s_ready", s_ready[g], (m_phase[g] == M_RUN) ? int'(c_ready) : 0);
         if (m_phase[g] == M_RUN && s_valid) chk("c_data_pix", c_data[g], s_data);
         if (m_phase[g] == M_DRAIN) chk("c_data_pad", c_data[g], 0);
         bt[g] = ecv & int'(c_ready);
         if (c_valid[g] && c_ready && s_ready[g])  o_pix[g]++;
         if (c_valid[g] && c_ready && !s_ready[g]) o_pad[g]++;
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         e_rv[g] = 0;
         e_rl[g] = 0;
         if (abort && m_phase[g] != M_IDLE) begin
            m_phase[g] = M_IDLE;
            e_rr[g] = 0;
            e_rc[g] = 0;
         end else begin
            case (m_phase[g])
               M_IDLE: if (start) begin
                  m_phase[g] = M_RUN; m_pix[g] = 0; m_nb[g] = 0; m_frames[g]++;
               end
               M_RUN: if (bt[g] != 0) begin
                  push(g, m_pix[g]);
                  m_pix[g]++;
                  if (m_pix[g] == NR * NC) begin
                     m_phase[g] = M_DRAIN; m_pads[g] = 0;
                  end
               end
               M_DRAIN: if (bt[g] != 0) begin
                  push(g, -1);
                  m_pads[g]++;
                  if (m_pads[g] == g + 1) m_phase[g] = M_DONE;
               end
               default: m_phase[g] = M_IDLE;
            endcase
         end
         chk("busy", busy[g], (m_phase[g] == M_RUN || m_phase[g] == M_DRAIN) ? 1 : 0);
         chk("done", done[g], (m_phase[g] == M_DONE) ? 1 : 0);
         chk("res_valid", rv[g], e_rv[g]);
         chk("res_last", rl[g], e_rl[g]);
         if (e_rv[g] != 0) begin
            chk("res_row", rr[g], e_rr[g]);
            chk("res_col", rc[g], e_rc[g]);
         end
         if (rv[g])   o_res[g]++;
         if (rl[g])   o_last[g]++;
         if (done[g]) o_done[g]++;
      end
   endtask

   task automatic cyc(input bit rnd);
      s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      c_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = 8'($urandom);
      tick();
   endtask

   task automatic wait_idle(input bit rnd);
      int guard = 0;
      while (!(m_phase[0] == M_IDLE && m_phase[1] == M_IDLE) && guard < 400) begin
         cyc(rnd);
         guard++;
      end
      chk("frame_timeout", (guard < 400) ? 1 : 0, 1);
   endtask

   task automatic frame(input bit rnd);
      start = 1'b1;
      cyc(rnd);
      start = 1'b0;
      wait_idle(rnd);
   endtask

   task automatic check_counts(input string tag, input int frames);
      for (int g = 0; g < 2; g++) begin
         chk({tag, "_pixels"}, o_pix[g],  frames * NR * NC);
         chk({tag, "_pads"},   o_pad[g],  frames * (g + 1));
         chk({tag, "_results"}, o_res[g], frames * (NR - 2) * (NC - 2));
         chk({tag, "_lasts"},  o_last[g], frames);
         chk({tag, "_dones"},  o_done[g], frames);
      end
   endtask

   initial begin
      int guard;
      rstn = 1'b0; start = 1'b0; abort = 1'b0;
      s_valid = 1'b0; c_ready = 1'b0; s_data = 8'd0;
      model_reset();
      clear_obs();
      #12;
      check_reset_outputs("reset");
      rstn = 1'b1;
      cyc(0);

      clear_obs();
      frame(0);
      check_counts("nostall", 1);

      clear_obs();
      frame(1);
      check_counts("stall", 1);

      clear_obs();
      start = 1'b1;
      guard = 0;
      while (!(m_frames[0] >= 2 && m_frames[1] >= 2) && guard < 400) begin
         cyc(1);
         guard++;
      end
      chk("hold_start_timeout", (guard < 400) ? 1 : 0, 1);
      start = 1'b0;
      wait_idle(1);
      check_counts("hold_start", 2);

      clear_obs();
      start = 1'b1;
      cyc(0);
      start = 1'b0;
      guard = 0;
      while (m_pix[0] < 9 && guard < 100) begin
         cyc(0);
         guard++;
      end
      abort = 1'b1;
      cyc(0);
      abort = 1'b0;
      chk("abort_busy", busy[0], 0);
      for (int i = 0; i < 3; i++) cyc(0);
      chk("abort_sready", s_ready[0], 0);
      chk("abort_no_done0", o_done[0], 0);
      chk("abort_no_done1", o_done[1], 0);
      clear_obs();
      frame(1);
      check_counts("after_abort", 1);

      start = 1'b1;
      cyc(0);
      start = 1'b0;
      guard = 0;
      while (m_phase[0] != M_DRAIN && guard < 100) begin
         cyc(0);
         guard++;
      end
      s_valid = 1'b1;
      c_ready = 1'b0;
      tick();
      tick();
      chk("drain_busy", busy[1], 1);
      rstn = 1'b0;
      #1;
      check_reset_outputs("mid_drain_reset");
      model_reset();
      @(posedge clk);
      #1;
      check_reset_outputs("held_reset");
      rstn = 1'b1;
      cyc(0);

      clear_obs();
      frame(1);
      check_counts("after_reset", 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
